grayscale_dma_ctrl: RTL and testbench



---
 rtl/grayscale_dma_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_grayscale_dma_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_dma_ctrl.sv
// RGB565-to-grayscale DMA sequencer driven over the custom-instruction bus.
// Optional completion interrupt output: define GRAYSCALE_DMA_IRQ_EN.
module grayscale_dma_ctrl #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  isId,
    output logic        done,
    output logic [31:0] result,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
`ifdef GRAYSCALE_DMA_IRQ_EN
    output logic        irq,
`endif
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD0  = 2'd1,
        ST_RD1  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] cnt_q;
    logic        done_flag_q;
    logic        abort_q;
    logic [31:0] w0_q;

    logic        s_sel_s;
    logic [2:0]  op_s;
    logic        busy_s;
    logic        op_src_s;
    logic        op_dst_s;
    logic        op_cnt_s;
    logic        go_s;
    logic        abort_s;
    logic [31:0] gray_s;
    logic        unused_valuea_s;

    // Luma from one RGB565 halfword whose bytes arrive swapped; truncating fixed point.
    function automatic logic [7:0] luma(input logic [15:0] h);
        logic [13:0] r;
        logic [13:0] g;
        logic [13:0] b;
        logic [13:0] acc;
        r   = {8'd0, h[7:3], 1'b0};
        g   = {8'd0, h[2:0], h[15:13]};
        b   = {8'd0, h[12:8], 1'b0};
        acc = 14'd54 * r + 14'd183 * g + 14'd19 * b;
        return acc[13:6];
    endfunction

    assign s_sel_s  = start && (isId == customInstructionId);
    assign op_s     = valueA[2:0];
    assign busy_s   = (state_q != ST_IDLE);
    assign op_src_s = s_sel_s && (op_s == 3'd0) && !busy_s;
    assign op_dst_s = s_sel_s && (op_s == 3'd1) && !busy_s;
    assign op_cnt_s = s_sel_s && (op_s == 3'd2) && !busy_s;
    assign go_s     = s_sel_s && (op_s == 3'd3) && !busy_s;
    assign abort_s  = s_sel_s && (op_s == 3'd5) && busy_s;
    assign gray_s   = {luma(w0_q[31:16]), luma(w0_q[15:0]),
                       luma(mem_rdata[31:16]), luma(mem_rdata[15:0])};
    assign done     = s_sel_s;
    assign unused_valuea_s = ^valueA[31:3];

    // CI result mux: only GO-while-busy and STAT return non-zero data.
    always_comb begin
        result = 32'd0;
        if (s_sel_s) begin
            case (op_s)
                3'd3:    result = {31'd0, busy_s};
                3'd4:    result = {busy_s, done_flag_q, 14'd0, cnt_q};
                default: result = 32'd0;
            endcase
        end else begin
            result = 32'd0;
        end
    end

    // Sequencer FSM with registered bus outputs and CI register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            cnt_q       <= 16'd0;
            done_flag_q <= 1'b0;
            abort_q     <= 1'b0;
            w0_q        <= 32'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
        end else begin
            if (abort_s) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (op_src_s) src_q <= {valueB[31:2], 2'b00};
                    if (op_dst_s) dst_q <= {valueB[31:2], 2'b00};
                    if (op_cnt_s) cnt_q <= valueB[15:0];
                    if (go_s) begin
                        if (cnt_q == 16'd0) begin
                            done_flag_q <= 1'b1;
                        end else begin
                            done_flag_q <= 1'b0;
                            state_q     <= ST_RD0;
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b0;
                            mem_addr    <= src_q;
                        end
                    end
                end
                ST_RD0: begin
                    if (mem_ack) begin
                        if (abort_q) begin
                            state_q <= ST_IDLE;
                            mem_req <= 1'b0;
                            abort_q <= 1'b0;
                        end else begin
                            w0_q     <= mem_rdata;
                            src_q    <= src_q + 32'd4;
                            mem_addr <= src_q + 32'd4;
                            state_q  <= ST_RD1;
                        end
                    end
                end
                ST_RD1: begin
                    if (mem_ack) begin
                        if (abort_q) begin
                            state_q <= ST_IDLE;
                            mem_req <= 1'b0;
                            abort_q <= 1'b0;
                        end else begin
                            src_q     <= src_q + 32'd4;
                            mem_we    <= 1'b1;
                            mem_addr  <= dst_q;
                            mem_wdata <= gray_s;
                            state_q   <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        if (abort_q) begin
                            state_q <= ST_IDLE;
                            mem_req <= 1'b0;
                            abort_q <= 1'b0;
                        end else begin
                            dst_q <= dst_q + 32'd4;
                            cnt_q <= cnt_q - 16'd1;
                            if (cnt_q == 16'd1) begin
                                // A same-cycle ABORT loses to normal completion.
                                state_q     <= ST_IDLE;
                                mem_req     <= 1'b0;
                                done_flag_q <= 1'b1;
                                abort_q     <= 1'b0;
                            end else begin
                                state_q  <= ST_RD0;
                                mem_addr <= src_q;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRAYSCALE_DMA_IRQ_EN
    logic final_wr_s;
    assign final_wr_s = (state_q == ST_WR) && mem_ack && !abort_q && (cnt_q == 16'd1);

    // Completion interrupt: set by the final write, cleared by STAT or GO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else if (final_wr_s) begin
            irq <= 1'b1;
        end else if (s_sel_s && ((op_s == 3'd3) || (op_s == 3'd4))) begin
            irq <= 1'b0;
        end else begin
            irq <= irq;
        end
    end
`endif

endmodule

// File: tb/tb_grayscale_dma_ctrl.sv
// Directed bench for grayscale_dma_ctrl with a simple memory responder.
module tb_grayscale_dma_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  isId;
    logic        done;
    logic [31:0] result;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef GRAYSCALE_DMA_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wait_cnt = 0;
    int ack_delay = 0;
    int log_n    = 0;
    logic [31:0] mem [0:255];
    logic [31:0] log_addr  [0:63];
    logic        log_we    [0:63];
    logic [31:0] log_wdata [0:63];
    int          log_cyc   [0:63];

    grayscale_dma_ctrl #(.customInstructionId(8'd0)) dut (
        .clock(clock), .reset(reset), .start(start), .valueA(valueA),
        .valueB(valueB), .isId(isId), .done(done), .result(result),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
`ifdef GRAYSCALE_DMA_IRQ_EN
        .irq(irq),
`endif
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: ack after ack_delay wait cycles, driven away from the active edge.
    always @(negedge clock) begin
        mem_ack   = mem_req && (wait_cnt >= ack_delay);
        mem_rdata = (mem_req && !mem_we) ? mem[mem_addr[9:2]] : 32'd0;
    end

    always @(posedge clock) begin
        cyc++;
        if (mem_ack && mem_req) begin
            if (log_n < 64) begin
                log_addr[log_n]  = mem_addr;
                log_we[log_n]    = mem_we;
                log_wdata[log_n] = mem_wdata;
                log_cyc[log_n]   = cyc;
            end
            log_n++;
            if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
            wait_cnt = 0;
        end else if (mem_req) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic ci(input logic [2:0] op, input logic [31:0] b,
                      output logic [31:0] res, output logic dn);
        start  = 1'b1;
        valueA = {29'd0, op};
        valueB = b;
        isId   = 8'd0;
        #1;
        res = result;
        dn  = done;
        @(negedge clock);
        start  = 1'b0;
        valueA = 32'd0;
        valueB = 32'd0;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int k = 0;
        while (log_n < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (log_n < target) check_eq("xfer_timeout", log_n, target);
    endtask

    logic [31:0] r;
    logic        d;
    int          n0;

    initial begin
        reset = 1'b0; start = 1'b0; valueA = 32'd0; valueB = 32'd0; isId = 8'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h40] = 32'hFFFFFFFF; mem[8'h41] = 32'h00000000;
        mem[8'h42] = 32'hE00700F8; mem[8'h43] = 32'h1F000000;
        mem[8'h44] = 32'h00000000; mem[8'h45] = 32'hFFFF00F8;

        repeat (2) @(negedge clock);
        check_eq("rst_req",   {31'd0, mem_req}, 32'd0);
        check_eq("rst_addr",  mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_done",  {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        ci(3'd4, 32'd0, r, d);
        check_eq("rst_stat", r, 32'd0);
        check_eq("stat_done", {31'd0, d}, 32'd1);

        // Unselected opcode and no-op ops
        start = 1'b1; isId = 8'h05; valueA = 32'd4; #1;
        check_eq("unsel_done", {31'd0, done}, 32'd0);
        check_eq("unsel_result", result, 32'd0);
        @(negedge clock); start = 1'b0; isId = 8'd0;
        ci(3'd6, 32'hFFFFFFFF, r, d);
        check_eq("op6_result", r, 32'd0);
        check_eq("op6_done", {31'd0, d}, 32'd1);

        // Single quad, zero wait
        n0 = log_n; ack_delay = 0;
        ci(3'd0, 32'h00000103, r, d);
        check_eq("src_result", r, 32'd0);
        ci(3'd1, 32'h00000200, r, d);
        ci(3'd2, 32'h00000001, r, d);
        ci(3'd3, 32'd0, r, d);
        check_eq("go_result", r, 32'd0);
        check_eq("t1_first_req", {31'd0, mem_req}, 32'd1);
        check_eq("t1_first_addr", mem_addr, 32'h00000100);
        wait_xfers(n0 + 3, 40);
        check_eq("t1_rd0_addr", log_addr[n0], 32'h00000100);
        check_eq("t1_rd1_addr", log_addr[n0 + 1], 32'h00000104);
        check_eq("t1_wr_we", {31'd0, log_we[n0 + 2]}, 32'd1);
        check_eq("t1_wr_addr", log_addr[n0 + 2], 32'h00000200);
        check_eq("t1_wr_data", log_wdata[n0 + 2], 32'hFAFA0000);
`ifdef GRAYSCALE_DMA_IRQ_EN
        check_eq("t1_irq_set", {31'd0, irq}, 32'd1);
`endif
        ci(3'd4, 32'd0, r, d);
        check_eq("t1_stat", r, 32'h40000000);
`ifdef GRAYSCALE_DMA_IRQ_EN
        check_eq("t1_irq_clr", {31'd0, irq}, 32'd0);
`endif

        // Three quads back to back
        n0 = log_n;
        ci(3'd0, 32'h00000100, r, d);
        ci(3'd1, 32'h00000200, r, d);
        ci(3'd2, 32'h00000003, r, d);
        ci(3'd3, 32'd0, r, d);
        wait_xfers(n0 + 9, 60);
        check_eq("t2_b2b", log_cyc[n0 + 8] - log_cyc[n0], 32'd8);
        check_eq("t2_wr0_addr", log_addr[n0 + 2], 32'h00000200);
        check_eq("t2_wr1_addr", log_addr[n0 + 5], 32'h00000204);
        check_eq("t2_wr2_addr", log_addr[n0 + 8], 32'h00000208);
        check_eq("t2_rd5_addr", log_addr[n0 + 7], 32'h00000114);
        check_eq("t2_wr0_data", log_wdata[n0 + 2], 32'hFAFA0000);
        check_eq("t2_wr1_data", log_wdata[n0 + 5], 32'hB4341200);
        check_eq("t2_wr2_data", log_wdata[n0 + 8], 32'h0000FA34);
        repeat (2) @(negedge clock);
        check_eq("t2_count", log_n, n0 + 9);

        // Continue from retained src/dst
        n0 = log_n;
        ci(3'd2, 32'h00000001, r, d);
        ci(3'd3, 32'd0, r, d);
        wait_xfers(n0 + 3, 40);
        check_eq("t2b_src_end", log_addr[n0], 32'h00000118);
        check_eq("t2b_dst", log_addr[n0 + 2], 32'h0000020C);

        // Abort while RD1 is stalled
        n0 = log_n; ack_delay = 5;
        ci(3'd0, 32'h00000100, r, d);
        ci(3'd1, 32'h00000300, r, d);
        ci(3'd2, 32'h00000002, r, d);
        ci(3'd3, 32'd0, r, d);
        wait_xfers(n0 + 1, 40);
        ci(3'd5, 32'd0, r, d);
        check_eq("ab_result", r, 32'd0);
        check_eq("ab_req_held", {31'd0, mem_req}, 32'd1);
        check_eq("ab_addr_held", mem_addr, 32'h00000104);
        wait_xfers(n0 + 2, 40);
        check_eq("ab_req_drop", {31'd0, mem_req}, 32'd0);
        ci(3'd4, 32'd0, r, d);
        check_eq("ab_stat", r, 32'h00000002);
        repeat (4) @(negedge clock);
        check_eq("ab_no_write", log_n, n0 + 2);
`ifdef GRAYSCALE_DMA_IRQ_EN
        check_eq("ab_irq", {31'd0, irq}, 32'd0);
`endif
        ci(3'd5, 32'd0, r, d);
        ci(3'd4, 32'd0, r, d);
        check_eq("ab_idle_noeffect", r, 32'h00000002);

        // Zero count GO
        n0 = log_n;
        ci(3'd2, 32'h00000000, r, d);
        ci(3'd3, 32'd0, r, d);
        check_eq("c0_req", {31'd0, mem_req}, 32'd0);
        ci(3'd4, 32'd0, r, d);
        check_eq("c0_stat", r, 32'h40000000);
        repeat (3) @(negedge clock);
        check_eq("c0_no_traffic", log_n, n0);

        // GO while busy
        n0 = log_n; ack_delay = 2;
        ci(3'd0, 32'h00000100, r, d);
        ci(3'd1, 32'h00000400, r, d);
        ci(3'd2, 32'h00000001, r, d);
        ci(3'd3, 32'd0, r, d);
        ci(3'd3, 32'd0, r, d);
        check_eq("busy_go_result", r, 32'd1);
        check_eq("busy_go_done", {31'd0, d}, 32'd1);
        ci(3'd4, 32'd0, r, d);
        check_eq("busy_stat", r, 32'h80000001);
        ci(3'd2, 32'h00000007, r, d);
        wait_xfers(n0 + 3, 40);
        check_eq("busy_wr_addr", log_addr[n0 + 2], 32'h00000400);
        check_eq("busy_wr_data", log_wdata[n0 + 2], 32'hFAFA0000);
        repeat (3) @(negedge clock);
        ci(3'd4, 32'd0, r, d);
        check_eq("busy_end_stat", r, 32'h40000000);
        check_eq("busy_count", log_n, n0 + 3);

        // Reset mid-write
        n0 = log_n; ack_delay = 3;
        ci(3'd2, 32'h00000001, r, d);
        ci(3'd3, 32'd0, r, d);
        for (int k = 0; k < 40 && !(mem_req && mem_we); k++) @(negedge clock);
        check_eq("rw_in_wr", {31'd0, mem_req && mem_we}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rw_req", {31'd0, mem_req}, 32'd0);
        check_eq("rw_we", {31'd0, mem_we}, 32'd0);
        check_eq("rw_addr", mem_addr, 32'd0);
        check_eq("rw_wdata", mem_wdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        ci(3'd4, 32'd0, r, d);
        check_eq("rw_stat", r, 32'd0);
        check_eq("rw_no_write", log_n, n0 + 2);
`ifdef GRAYSCALE_DMA_IRQ_EN
        check_eq("rw_irq", {31'd0, irq}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
